// File: rtl/gray_seq_gen.sv
// Gray-code sequence source: walks a binary counter up/down from a seed and emits
// registered Gray words under valid/ready. Optional adjacency checker: GRAY_SEQ_STEPCHK_EN.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] len,
  input  logic             abort,
  output logic [WIDTH-1:0] g,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             busy,
  output logic             done,
  output logic             step_err
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin, bin_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic             dir_q, dir_nxt;
  logic             wrap_q, wrap_nxt;
  logic             load, accept;

  assign load   = (state == S_IDLE) && start && !abort;
  assign accept = (state == S_EMIT) && g_ready && !abort;

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin;
    rem_nxt   = rem;
    dir_nxt   = dir_q;
    wrap_nxt  = wrap_q;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state_nxt = S_EMIT;
          bin_nxt   = seed;
          rem_nxt   = len;
          dir_nxt   = dir;
          wrap_nxt  = wrap_en;
        end
        S_EMIT: if (g_ready) begin
          if (!wrap_q && (rem == '0)) begin
            state_nxt = S_DONE;
          end else begin
            bin_nxt = dir_q ? (bin - ONE) : (bin + ONE);
            if (!wrap_q) rem_nxt = rem - ONE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      bin    <= '0;
      rem    <= '0;
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
      g      <= '0;
    end else begin
      state  <= state_nxt;
      bin    <= bin_nxt;
      rem    <= rem_nxt;
      dir_q  <= dir_nxt;
      wrap_q <= wrap_nxt;
      // g only moves when the counter does, so it holds under backpressure and in IDLE/DONE
      if (load || accept) g <= bin_nxt ^ (bin_nxt >> 1);
    end
  end

  assign g_valid = (state == S_EMIT);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

`ifdef GRAY_SEQ_STEPCHK_EN
  logic [WIDTH-1:0] prev_g;
  logic [WIDTH-1:0] diff;
  logic             first_q;
  logic             err_q;

  assign diff = g ^ prev_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_g  <= '0;
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else if (load) begin
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else if (accept) begin
      prev_g  <= g;
      first_q <= 1'b0;
      // exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero
      if (!first_q && ((diff == '0) || ((diff & (diff - ONE)) != '0))) err_q <= 1'b1;
    end
  end

  assign step_err = err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_gen.sv
// Randomized self-checking bench for gray_seq_gen; expected codes come from a
// reflected-construction Gray table indexed by the modular sweep position.
module tb_gray_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, dir = 1'b0, wrap_en = 1'b0, abort = 1'b0, g_ready = 1'b0;
  logic [3:0] seed = '0, len = '0;
  logic [3:0] g;
  logic       g_valid, busy, done, step_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] gray_tab [16];

  gray_seq_gen #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .wrap_en(wrap_en),
    .seed(seed), .len(len), .abort(abort), .g(g), .g_valid(g_valid),
    .g_ready(g_ready), .busy(busy), .done(done), .step_err(step_err)
  );

  always #5 clk = ~clk;

  // Gray list by reflection: new half = old half reversed with the next bit set.
  task automatic build_table();
    int n = 1;
    gray_tab[0] = 4'd0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < n; i++) gray_tab[n + i] = gray_tab[n - 1 - i] | 4'(1 << b);
      n = n * 2;
    end
  endtask

  // What the downstream converter would produce: prefix XOR from the MSB.
  function automatic logic [3:0] g2b(input logic [3:0] x);
    logic [3:0] b;
    b[3] = x[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i + 1] ^ x[i];
    return b;
  endfunction

  function automatic int pos(input logic [3:0] sd, input logic d, input int k);
    return d ? ((int'(sd) - k) & 15) : ((int'(sd) + k) & 15);
  endfunction

  // Single sweep with random backpressure; optional 3-cycle stall at code hold_at
  // and an ignored start pulse at code poke_at. Returns at the negedge of the IDLE
  // cycle after done, so the caller may restart at the earliest legal point.
  task automatic do_sweep(input logic [3:0] sd, input logic [3:0] ln, input logic d,
                          input int rdy_pct, input int hold_at, input int poke_at,
                          input string nm);
    int n = int'(ln) + 1;
    int k = 0;
    int cyc = 0;
    int hold_left = 3;
    bit poked = 0;
    logic acc;
    logic [3:0] exp_g;
    logic [3:0] last_g;
    seed = sd; len = ln; dir = d; wrap_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    last_g = gray_tab[pos(sd, d, 0)];
    while (k < n && cyc < 400) begin
      if (k == hold_at && hold_left > 0) begin
        g_ready = 1'b0; hold_left--;
      end else begin
        g_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      if (k == poke_at && !poked) begin
        start = 1'b1; seed = ~sd; dir = ~d; wrap_en = 1'b1; poked = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      exp_g  = gray_tab[pos(sd, d, k)];
      last_g = exp_g;
      n_chk++;
      if (g_valid !== 1'b1 || g !== exp_g) begin
        n_fail++;
        $display("FAIL %s code k=%0d: got g=%b valid=%b, want g=%b valid=1", nm, k, g, g_valid, exp_g);
      end
      n_chk++;
      if (g2b(g) !== 4'(pos(sd, d, k))) begin
        n_fail++;
        $display("FAIL %s conv k=%0d: got bin=%0d, want %0d", nm, k, g2b(g), pos(sd, d, k));
      end
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s emit_flags k=%0d: got done=%b busy=%b, want done=0 busy=1", nm, k, done, busy);
      end
      acc = g_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    start = 1'b0; wrap_en = 1'b0;
    n_chk++;
    if (cyc >= 400) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d accepts, want %0d", nm, k, n);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || g_valid !== 1'b0 || busy !== 1'b1 || g !== last_g || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_cycle: got done=%b valid=%b busy=%b g=%b err=%b, want 1 0 1 %b 0",
               nm, done, g_valid, busy, g, step_err, last_g);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || g_valid !== 1'b0 || g !== last_g) begin
      n_fail++;
      $display("FAIL %s idle_after: got done=%b busy=%b valid=%b g=%b, want 0 0 0 %b",
               nm, done, busy, g_valid, g, last_g);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); dir = 1'($urandom); wrap_en = 1'($urandom); abort = 1'($urandom);
      g_ready = 1'($urandom); seed = 4'($urandom); len = 4'($urandom);
      @(negedge clk);
      n_chk++;
      if (g !== 4'b0000 || g_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || step_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset: got g=%b valid=%b busy=%b done=%b err=%b, want all 0",
                 g, g_valid, busy, done, step_err);
      end
    end
    start = 1'b0; abort = 1'b0; g_ready = 1'b0; wrap_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_up_sweep();
    do_sweep(4'd0, 4'd15, 1'b0, 100, -1, -1, "up_sweep");
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_g;
    seed = 4'b0010; dir = 1'b1; wrap_en = 1'b1; len = 4'($urandom); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wrap_en = 1'b0; g_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      exp_g = gray_tab[pos(4'b0010, 1'b1, k)];
      n_chk++;
      if (g_valid !== 1'b1 || g !== exp_g || done !== 1'b0) begin
        n_fail++;
        $display("FAIL down_wrap k=%0d: got g=%b valid=%b done=%b, want g=%b valid=1 done=0",
                 k, g, g_valid, done, exp_g);
      end
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; g_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (g_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort cyc=%0d: got valid=%b done=%b busy=%b, want 0 0 0", i, g_valid, done, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    do_sweep(4'd0, 4'd15, 1'b0, 100, 2, -1, "backpressure");
  endtask

  task automatic test_conflicts();
    do_sweep(4'd9, 4'd7, 1'b1, 100, -1, 3, "start_in_emit");
    seed = 4'd4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (g_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL start_abort cyc=%0d: got valid=%b busy=%b done=%b, want 0 0 0", i, g_valid, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_sweep(4'd14, 4'd3, 1'b0, 100, -1, -1, "b2b_a");
    do_sweep(4'd1, 4'd4, 1'b1, 100, -1, -1, "b2b_b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      do_sweep(4'($urandom), 4'($urandom), 1'($urandom), 60, -1, -1, "random");
  endtask

  task automatic test_reset_len0();
    seed = 4'd3; len = 4'd15; dir = 1'b0; wrap_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; g_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (g !== 4'b0000 || g_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got g=%b valid=%b busy=%b done=%b err=%b, want all 0",
               g, g_valid, busy, done, step_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got done=%b busy=%b, want 0 0", done, busy);
    end
    seed = 4'b0101; len = 4'd0; dir = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (g !== 4'b0111 || g_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL len0_code: got g=%b valid=%b, want g=0111 valid=1", g, g_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || g_valid !== 1'b0 || g !== 4'b0111) begin
      n_fail++;
      $display("FAIL len0_done: got done=%b valid=%b g=%b, want 1 0 0111", done, g_valid, g);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_up_sweep();
    test_down_wrap();
    test_backpressure();
    test_conflicts();
    test_back_to_back();
    test_random();
    test_reset_len0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
